// File: rtl/rfid_seq_pkg.sv
// Shared FSM encoding and Wishbone register map for the RFID channel sequencer.
package rfid_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_WR,
        ST_DWELL,
        ST_RD,
        ST_DESEL,
        ST_DONE
    } seq_state_t;

    localparam logic [2:0] ADDR_CTRL = 3'h0;
    localparam logic [2:0] ADDR_DATA = 3'h1;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rfid_ch_pick.sv
// Lowest-set-bit picker: returns the index and one-hot select of the
// lowest pending channel in the mask.
module rfid_ch_pick #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] mask,
    output logic [CH_W-1:0]   idx,
    output logic [NUM_CH-1:0] onehot
);

    // Scan from the top so the last hit, and therefore the winner, is the lowest bit.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx    = CH_W'(i);
                onehot = NUM_CH'(1) << i;
            end
        end
    end

endmodule

// File: rtl/rfid_chan_sequencer.sv
// Walks the requested SPI front-end channels over Wishbone: control write, dwell, data read.
// Optional ack timeout enabled by defining RFID_SEQ_WB_TIMEOUT_EN.
module rfid_chan_sequencer
    import rfid_seq_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DAT_W  = 8,
    parameter int ADR_W  = 3,
    parameter int DWELL  = 8,
    parameter int TMO    = 15
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    output logic                            cyc_o,
    output logic                            stb_o,
    output logic                            we_o,
    output logic [ADR_W-1:0]                adr_o,
    output logic [DAT_W-1:0]                dat_o,
    input  logic [DAT_W-1:0]                dat_i,
    input  logic                            ack_i,
    input  logic                            inta_i,
    input  logic                            start_i,
    input  logic [NUM_CH-1:0]               ch_mask_i,
    input  logic [DAT_W-1:0]                wr_data_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic [DAT_W-1:0]                rd_data_o,
    output logic                            rd_valid_o,
    output logic [ch_idx_w(NUM_CH)-1:0]     rd_ch_o,
    output logic [NUM_CH-1:0]               spi_cs_o
);

    localparam int CH_W = ch_idx_w(NUM_CH);

`ifdef RFID_SEQ_WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    seq_state_t        state, state_nxt;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] pick_onehot;
    logic [CH_W-1:0]   pick_idx;
    logic [DAT_W-1:0]  word_q;
    logic [DAT_W-1:0]  rd_data_q;
    logic [CH_W-1:0]   rd_ch_q;
    logic              rd_valid_q;
    logic              err_q;
    logic [7:0]        cnt;
    logic              dwell_end;
    logic              tmo_hit;

    rfid_ch_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .mask   (mask_q),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign dwell_end = inta_i || (cnt == 8'(DWELL - 1));
    assign tmo_hit   = TMO_EN && (cnt == 8'(TMO - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = (ch_mask_i != '0) ? ST_SEL : ST_DONE;
            ST_SEL:   state_nxt = ST_WR;
            ST_WR: begin
                if (ack_i)        state_nxt = ST_DWELL;
                else if (tmo_hit) state_nxt = ST_DONE;
            end
            ST_DWELL: if (dwell_end) state_nxt = ST_RD;
            ST_RD: begin
                if (ack_i)        state_nxt = ST_DESEL;
                else if (tmo_hit) state_nxt = ST_DONE;
            end
            ST_DESEL: state_nxt = ((mask_q & ~pick_onehot) != '0) ? ST_SEL : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Chip select stays low from SEL through RD; DESEL and DONE release it.
    always_comb begin
        cyc_o    = 1'b0;
        we_o     = 1'b0;
        adr_o    = ADR_W'(ADDR_CTRL);
        dat_o    = '0;
        spi_cs_o = '1;
        busy_o   = (state != ST_IDLE);
        done_o   = (state == ST_DONE);
        case (state)
            ST_SEL, ST_DWELL: spi_cs_o = ~pick_onehot;
            ST_WR: begin
                cyc_o    = 1'b1;
                we_o     = 1'b1;
                dat_o    = word_q;
                spi_cs_o = ~pick_onehot;
            end
            ST_RD: begin
                cyc_o    = 1'b1;
                adr_o    = ADR_W'(ADDR_DATA);
                spi_cs_o = ~pick_onehot;
            end
            default: ;
        endcase
    end

    assign stb_o      = cyc_o;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_ch_o    = rd_ch_q;
    assign err_o      = TMO_EN ? err_q : 1'b0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mask_q     <= '0;
            word_q     <= '0;
            rd_data_q  <= '0;
            rd_ch_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            cnt        <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            rd_valid_q <= 1'b0;
            if (state == ST_IDLE && start_i) begin
                err_q <= 1'b0;
                if (ch_mask_i != '0) begin
                    mask_q <= ch_mask_i;
                    word_q <= wr_data_i;
                end
            end
            if (state == ST_RD && ack_i) begin
                rd_data_q  <= dat_i;
                rd_ch_q    <= pick_idx;
                rd_valid_q <= 1'b1;
            end
            if (state == ST_DESEL) begin
                mask_q <= mask_q & ~pick_onehot;
            end
            if ((state == ST_WR || state == ST_RD) && !ack_i && tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfid_chan_sequencer.sv
// Randomized self-checking bench for rfid_chan_sequencer; the expected transaction
// order is derived from the mask, and dwell length from min(inta position, DWELL).
module tb_rfid_chan_sequencer;

    localparam int NUM_CH = 2;
    localparam int DAT_W  = 8;
    localparam int ADR_W  = 3;
    localparam int DWELL  = 8;
    localparam int TMO    = 15;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cyc_o, stb_o, we_o;
    logic [ADR_W-1:0]  adr_o;
    logic [DAT_W-1:0]  dat_o;
    logic [DAT_W-1:0]  dat_i;
    logic              ack_i, inta_i, start_i;
    logic [NUM_CH-1:0] ch_mask_i;
    logic [DAT_W-1:0]  wr_data_i;
    logic              busy_o, done_o, err_o;
    logic [DAT_W-1:0]  rd_data_o;
    logic              rd_valid_o;
    logic [0:0]        rd_ch_o;
    logic [NUM_CH-1:0] spi_cs_o;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;
`ifdef RFID_SEQ_WB_TIMEOUT_EN
    bit ch1_seen = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    rfid_chan_sequencer #(
        .NUM_CH (NUM_CH),
        .DAT_W  (DAT_W),
        .ADR_W  (ADR_W),
        .DWELL  (DWELL),
        .TMO    (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .ack_i      (ack_i),
        .inta_i     (inta_i),
        .start_i    (start_i),
        .ch_mask_i  (ch_mask_i),
        .wr_data_i  (wr_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_ch_o    (rd_ch_o),
        .spi_cs_o   (spi_cs_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Background monitor: pulse counters and the cyc/stb pairing every cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (done_o) done_cnt++;
            if (rd_valid_o) rv_cnt++;
            checkOutput("cyc_eq_stb", stb_o, cyc_o);
`ifdef RFID_SEQ_WB_TIMEOUT_EN
            if (!spi_cs_o[1]) ch1_seen = 1'b1;
`else
            checkOutput("err_tied0", err_o, 0);
`endif
        end
    end

    // Acts as the Wishbone slave for one transfer, acking after ack_dly wait cycles.
    task automatic bus_phase(input string tag, input bit exp_we, input logic [2:0] exp_adr,
                             input logic [7:0] exp_dat, input logic [NUM_CH-1:0] exp_cs,
                             input int ack_dly, input logic [7:0] rdat, input bit poke);
        int n = 0;
        while (!cyc_o && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput({tag, "_cyc_up"}, cyc_o, 1);
        if (!cyc_o) return;
        for (int i = 0; i <= ack_dly; i++) begin
            checkOutput({tag, "_cyc"}, cyc_o, 1);
            checkOutput({tag, "_we"}, we_o, exp_we);
            checkOutput({tag, "_adr"}, adr_o, exp_adr);
            checkOutput({tag, "_cs"}, spi_cs_o, exp_cs);
            if (exp_we) checkOutput({tag, "_dat"}, dat_o, exp_dat);
            if (i == ack_dly) begin
                dat_i = rdat;
                ack_i = 1'b1;
            end else if (poke && i == 0) begin
                start_i   = 1'b1;
                ch_mask_i = NUM_CH'(2);
                wr_data_i = ~exp_dat;
            end
            @(negedge clk_i);
            ack_i   = 1'b0;
            start_i = 1'b0;
            dat_i   = 8'($urandom);
        end
        checkOutput({tag, "_cyc_drop"}, cyc_o, 0);
    endtask

    // Counts idle-bus cycles between write and read; spurious acks must be ignored.
    task automatic dwell_phase(input logic [NUM_CH-1:0] exp_cs, input int inta_at);
        int k = 0;
        int exp_len;
        exp_len = (inta_at >= 1 && inta_at <= DWELL) ? inta_at : DWELL;
        while (!cyc_o && k < 300) begin
            k++;
            checkOutput("dwell_cs", spi_cs_o, exp_cs);
            inta_i = (k == inta_at);
            ack_i  = 1'($urandom_range(0, 1));
            @(negedge clk_i);
        end
        inta_i = 1'b0;
        ack_i  = 1'b0;
        checkOutput("dwell_len", k, exp_len);
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input logic [7:0] word,
                                 input int ack_dly, input int inta_at, input bit poke,
                                 input int rd_fix);
        int chs[$];
        int d0, r0;
        logic [NUM_CH-1:0] exp_cs;
        logic [7:0] rdat;
        for (int i = 0; i < NUM_CH; i++) if (mask[i]) chs.push_back(i);
        checkOutput("idle_before_start", busy_o, 0);
        d0 = done_cnt;
        r0 = rv_cnt;
        start_i   = 1'b1;
        ch_mask_i = mask;
        wr_data_i = word;
        @(negedge clk_i);
        start_i   = 1'b0;
        ch_mask_i = NUM_CH'($urandom);
        wr_data_i = 8'($urandom);
        if (chs.size() == 0) begin
            checkOutput("zero_done", done_o, 1);
            checkOutput("zero_cyc", cyc_o, 0);
            @(negedge clk_i);
            checkOutput("zero_cyc_after", cyc_o, 0);
            checkOutput("zero_busy", busy_o, 0);
            checkOutput("zero_done_cnt", done_cnt - d0, 1);
            return;
        end
        checkOutput("busy", busy_o, 1);
        foreach (chs[j]) begin
            exp_cs = '1;
            exp_cs[chs[j]] = 1'b0;
            rdat = (rd_fix >= 0) ? 8'(rd_fix) : 8'($urandom);
            bus_phase("wr", 1'b1, 3'h0, word, exp_cs, ack_dly, 8'($urandom), poke && j == 0);
            dwell_phase(exp_cs, inta_at);
            bus_phase("rd", 1'b0, 3'h1, 8'h00, exp_cs, ack_dly, rdat, 1'b0);
            checkOutput("rd_valid", rd_valid_o, 1);
            checkOutput("rd_ch", rd_ch_o, chs[j]);
            checkOutput("rd_data", rd_data_o, rdat);
            checkOutput("desel_cs", spi_cs_o, {NUM_CH{1'b1}});
            @(negedge clk_i);
            checkOutput("rd_valid_pulse", rd_valid_o, 0);
            checkOutput("done_o", done_o, (j == chs.size() - 1));
        end
        @(negedge clk_i);
        checkOutput("idle_after_done", busy_o, 0);
        checkOutput("err_clear", err_o, 0);
        checkOutput("done_cnt", done_cnt - d0, 1);
        checkOutput("rv_cnt", rv_cnt - r0, chs.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_cyc"}, cyc_o, 0);
        checkOutput({tag, "_stb"}, stb_o, 0);
        checkOutput({tag, "_we"}, we_o, 0);
        checkOutput({tag, "_adr"}, adr_o, 0);
        checkOutput({tag, "_dat"}, dat_o, 0);
        checkOutput({tag, "_rd_data"}, rd_data_o, 0);
        checkOutput({tag, "_rd_ch"}, rd_ch_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
        checkOutput({tag, "_rd_valid"}, rd_valid_o, 0);
        checkOutput({tag, "_cs"}, spi_cs_o, {NUM_CH{1'b1}});
    endtask

    // Abandon a transfer in RD with an asynchronous reset, then run a clean sequence.
    task automatic reset_test();
        int d0;
        start_i   = 1'b1;
        ch_mask_i = 2'b11;
        wr_data_i = 8'h96;
        @(negedge clk_i);
        start_i = 1'b0;
        bus_phase("rst_wr", 1'b1, 3'h0, 8'h96, 2'b10, 1, 8'h00, 1'b0);
        dwell_phase(2'b10, 2);
        checkOutput("rst_in_rd", we_o, 0);
        d0 = done_cnt;
        #2 rst_i = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_no_done", done_cnt - d0, 0);
        checkOutput("rst_idle", busy_o, 0);
        applyStimulus(2'b11, 8'hC3, 1, 5, 1'b0, -1);
    endtask

`ifdef RFID_SEQ_WB_TIMEOUT_EN
    task automatic tmo_test();
        int n = 0;
        int d0;
        d0 = done_cnt;
        ch1_seen  = 1'b0;
        start_i   = 1'b1;
        ch_mask_i = 2'b11;
        wr_data_i = 8'h77;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!cyc_o && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        n = 0;
        while (cyc_o && n < 100) begin
            n++;
            checkOutput("tmo_cs", spi_cs_o, 2'b10);
            @(negedge clk_i);
        end
        checkOutput("tmo_len", n, TMO);
        checkOutput("tmo_done", done_o, 1);
        checkOutput("tmo_err", err_o, 1);
        checkOutput("tmo_cs_off", spi_cs_o, 2'b11);
        @(negedge clk_i);
        checkOutput("tmo_err_sticky", err_o, 1);
        checkOutput("tmo_idle", busy_o, 0);
        repeat (3) @(negedge clk_i);
        checkOutput("tmo_ch1_skipped", ch1_seen, 0);
        checkOutput("tmo_done_cnt", done_cnt - d0, 1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=time_limit expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i     = 1'b0;
        start_i   = 1'b0;
        ch_mask_i = '0;
        wr_data_i = '0;
        dat_i     = '0;
        ack_i     = 1'b0;
        inta_i    = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        $display("[TB] directed sequences");
        applyStimulus(2'b11, 8'hA5, 2, 3, 1'b0, 8'h3C);
        applyStimulus(2'b10, 8'h4E, 1, 0, 1'b0, -1);
        applyStimulus(2'b00, 8'h11, 0, 0, 1'b0, -1);
        applyStimulus(2'b11, 8'h5A, 3, 4, 1'b1, -1);
        reset_test();
`ifdef RFID_SEQ_WB_TIMEOUT_EN
        tmo_test();
`endif

        $display("[TB] randomized sequences");
        for (int t = 0; t < 25; t++) begin
            applyStimulus(NUM_CH'($urandom_range(0, 3)), 8'($urandom),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 11)),
                          1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rfid_chan_sequencer.md
RFID_CHAN_SEQUENCER -- requirements
Module: rfid_chan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of SPI front-end channels (1..8).
REQ-002 SHALL have parameter DAT_W, default 8, Wishbone data width.
REQ-003 SHALL have parameter ADR_W, default 3, Wishbone address width.
REQ-004 SHALL have parameter DWELL, default 8, max cycles to wait for inta_i per channel (1..255).
REQ-005 SHALL have parameter TMO, default 15, ack timeout in cycles (1..255).
REQ-006 SHALL have ports, clock and reset first: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-low.
REQ-007 SHALL have cyc_o out 1, stb_o out 1, we_o out 1, adr_o out ADR_W, dat_o out DAT_W, dat_i in DAT_W, ack_i in 1, inta_i in 1 (Wishbone master, interrupt from slave).
REQ-008 SHALL have start_i in 1 (pulse), ch_mask_i in NUM_CH (channels to service), wr_data_i in DAT_W (control word).
REQ-009 SHALL have busy_o out 1, done_o out 1 (pulse), err_o out 1 (sticky until next start), rd_data_o out DAT_W, rd_valid_o out 1 (pulse), rd_ch_o out clog2(NUM_CH) (max 1), spi_cs_o out NUM_CH (active-low).

Function
REQ-010 SHALL implement states IDLE, SEL, WR, DWELL, RD, DESEL, DONE.
REQ-011 IDLE: start_i=1 with ch_mask_i!=0 SHALL latch mask and wr_data_i, go SEL next cycle; start_i with mask 0 SHALL pulse done_o one cycle later, no bus activity.
REQ-012 start_i while busy_o=1 SHALL be ignored.
REQ-013 SEL: lowest set bit of latched mask SHALL be chosen; its spi_cs_o bit driven 0 (one-hot-low), others 1; go WR.
REQ-014 WR: cyc_o=stb_o=we_o=1, adr_o=ADDR_CTRL, dat_o=latched word; held stable until ack_i sampled 1; then cyc_o/stb_o drop next cycle, go DWELL.
REQ-015 DWELL: leave on first cycle inta_i=1 or after DWELL cycles, whichever first; go RD.
REQ-016 RD: cyc_o=stb_o=1, we_o=0, adr_o=ADDR_DATA; on ack_i capture dat_i into rd_data_o, pulse rd_valid_o with rd_ch_o=channel index, go DESEL.
REQ-017 DESEL: deassert chip select, clear channel's mask bit; mask remaining !=0 -> SEL, else DONE.
REQ-018 DONE: pulse done_o one cycle, return IDLE; busy_o=1 in all states except IDLE.
REQ-019 ack_i outside WR/RD SHALL be ignored; cyc_o and stb_o SHALL always be equal.
REQ-020 Counters SHALL be 8-bit saturating-free, cleared on every state entry; no wrap possible within parameter ranges.

Reset
REQ-021 rst_i=0 SHALL immediately force IDLE, cyc_o/stb_o/we_o=0, adr_o/dat_o/rd_data_o=0, rd_ch_o=0, busy_o/done_o/err_o/rd_valid_o=0, spi_cs_o all 1.
REQ-022 Reset mid-transfer SHALL abandon the bus cycle with no done_o pulse; first start_i after release SHALL be honoured.

Configuration
REQ-023 With RFID_SEQ_WB_TIMEOUT_EN defined, no ack_i within TMO cycles in WR or RD SHALL drop cyc_o/stb_o, deassert chip select, set err_o, go DONE (remaining channels skipped).
REQ-024 Without RFID_SEQ_WB_TIMEOUT_EN, WR/RD SHALL wait indefinitely and err_o SHALL be tied 0.

Structure
REQ-025 Package rfid_seq_pkg SHALL hold state encoding and constants ADDR_CTRL=3'h0, ADDR_DATA=3'h1.
REQ-026 Sub-module rfid_ch_pick SHALL compute lowest-set-bit index and one-hot select from the mask (combinational).

Verification
REQ-027 NUM_CH=2, mask=2'b11, wr=8'hA5, ack after 2 cycles, inta_i at dwell cycle 3, dat_i=8'h3C -> writes A5 to adr 0, reads ch0 then ch1, two rd_valid_o pulses rd_ch_o=0,1, one done_o.
REQ-028 mask=2'b10, inta_i never -> only spi_cs_o[1] low, DWELL held exactly 8 cycles, rd_ch_o=1.
REQ-029 Timeout enabled, ack_i never in WR, mask=2'b11 -> cyc_o drops after 15 cycles, err_o=1, done_o, ch1 never selected.
REQ-030 start_i with mask=0 -> done_o one cycle later, cyc_o never high.
REQ-031 rst_i low during RD -> outputs at reset values same cycle, no done_o; new start_i runs full sequence.
REQ-032 start_i pulsed during WR -> ignored, sequence and latched word unchanged.
